csr_unit: RTL and testbench



---
 rtl/csr_unit.sv | 151 +++++++++++++++
 tb/tb_csr_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap sequencer.
// Executes CSR read-modify-write, ecall/mret redirects and 64-bit counters.
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        csr_used_i,
  input  logic [2:0]  csr_op_i,
  input  logic        csr_imm_i,
  input  logic [11:0] csr_addr_i,
  input  logic [4:0]  csr_zimm5_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [31:0] rs1_i,
  input  logic        is_ecall_i,
  input  logic        is_mret_i,
  output logic [31:0] csr_rdata_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        illegal_o
);

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mscratch;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic [31:0] w_src;
  logic        w_src_zero;
  logic        w_impl;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_ro;
  logic        w_onehot;
  logic        w_wr_req;
  logic        w_illegal;
  logic        w_trap;
  logic        w_mret;
  logic        w_wen;

  assign w_src      = csr_imm_i ? {27'd0, csr_zimm5_i} : rs1_i;
  assign w_src_zero = csr_imm_i ? (csr_zimm5_i == 5'd0)
                                : (rs1_addr_i == 5'd0);

  always_comb begin
    w_impl = 1'b1;
    w_old  = 32'd0;
    case (csr_addr_i)
      12'h300: w_old = {19'd0, 2'b11, 3'd0, r_mpie,
                        3'd0, r_mie, 3'd0};
      12'h301: w_old = MISA_VAL;
      12'h305: w_old = r_mtvec;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'hB00: w_old = r_mcycle[31:0];
      12'hB80: w_old = r_mcycle[63:32];
      12'hB02: w_old = r_minstret[31:0];
      12'hB82: w_old = r_minstret[63:32];
      12'hF14: w_old = HART_ID;
      default: w_impl = 1'b0;
    endcase
  end

  always_comb begin
    w_new = w_old;
    case (csr_op_i)
      3'b001:  w_new = w_src;
      3'b010:  w_new = w_old | w_src;
      3'b100:  w_new = w_old & ~w_src;
      default: w_new = w_old;
    endcase
  end

  assign w_ro      = (csr_addr_i[11:10] == 2'b11)
                   || (csr_addr_i == 12'h301);
  assign w_onehot  = (csr_op_i == 3'b001) || (csr_op_i == 3'b010)
                   || (csr_op_i == 3'b100);
  // RS/RC with a zero source index is a pure read
  assign w_wr_req  = (csr_op_i == 3'b001) || !w_src_zero;
  assign w_illegal = valid_i && csr_used_i
                   && (!w_impl || !w_onehot || (w_wr_req && w_ro));
  assign w_trap    = valid_i && (w_illegal || is_ecall_i);
  assign w_mret    = valid_i && is_mret_i && !w_trap;
  assign w_wen     = valid_i && csr_used_i && !w_illegal
                   && w_wr_req && !is_ecall_i && !is_mret_i;

  assign csr_rdata_o   = w_illegal ? 32'd0 : w_old;
  assign redirect_o    = !rst_i && (w_trap || w_mret);
  assign redirect_pc_o = w_trap ? r_mtvec : r_mepc;
  assign illegal_o     = w_illegal;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= MTVEC_RESET;
      r_mepc     <= 32'd0;
      r_mcause   <= 32'd0;
      r_mscratch <= 32'd0;
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
    end else begin
      if (w_trap) begin
        r_mepc   <= {pc_i[31:2], 2'b00};
        r_mcause <= w_illegal ? 32'd2 : 32'd11;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (w_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (w_wen) begin
        case (csr_addr_i)
          12'h300: begin
            r_mie  <= w_new[3];
            r_mpie <= w_new[7];
          end
          12'h305: r_mtvec    <= {w_new[31:2], 2'b00};
          12'h340: r_mscratch <= w_new;
          12'h341: r_mepc     <= {w_new[31:2], 2'b00};
          12'h342: r_mcause   <= w_new;
          default: ;
        endcase
      end

      // a write to either half replaces that edge's increment
      if (w_wen && csr_addr_i == 12'hB00)
        r_mcycle[31:0] <= w_new;
      else if (w_wen && csr_addr_i == 12'hB80)
        r_mcycle[63:32] <= w_new;
      else
        r_mcycle <= r_mcycle + 64'd1;

      if (w_wen && csr_addr_i == 12'hB02)
        r_minstret[31:0] <= w_new;
      else if (w_wen && csr_addr_i == 12'hB82)
        r_minstret[63:32] <= w_new;
      else if (valid_i && !w_trap)
        r_minstret <= r_minstret + 64'd1;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit with an expectation queue.
// Inputs change on negedge; outputs are checked 2ns later.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] pc;
  logic        used;
  logic [2:0]  op;
  logic        imm;
  logic [11:0] addr;
  logic [4:0]  zimm;
  logic [4:0]  rs1a;
  logic [31:0] rs1;
  logic        ecall;
  logic        mret;
  logic [31:0] rdata;
  logic        redir;
  logic [31:0] rpc;
  logic        ill;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [2:0] RW = 3'b001;
  localparam logic [2:0] RS = 3'b010;
  localparam logic [2:0] RC = 3'b100;

  csr_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .valid_i      (valid),
    .pc_i         (pc),
    .csr_used_i   (used),
    .csr_op_i     (op),
    .csr_imm_i    (imm),
    .csr_addr_i   (addr),
    .csr_zimm5_i  (zimm),
    .rs1_addr_i   (rs1a),
    .rs1_i        (rs1),
    .is_ecall_i   (ecall),
    .is_mret_i    (mret),
    .csr_rdata_o  (rdata),
    .redirect_o   (redir),
    .redirect_pc_o(rpc),
    .illegal_o    (ill)
  );

  always #5 clk = ~clk;

  task automatic idle();
    valid = 1'b0; used = 1'b0; op = RS; imm = 1'b0;
    addr = 12'h000; zimm = 5'd0; rs1a = 5'd0; rs1 = 32'd0;
    ecall = 1'b0; mret = 1'b0; pc = 32'd0;
  endtask

  task automatic csrop(input logic [2:0] o, input logic im,
                       input logic [11:0] a, input logic [4:0] idx,
                       input logic [31:0] v);
    idle();
    valid = 1'b1; used = 1'b1; op = o; imm = im;
    addr = a; zimm = idx; rs1a = idx; rs1 = v;
  endtask

  task automatic exp(input string t, input int s,
                     input logic [31:0] v);
    exp_t e;
    e.tag = t; e.sel = s; e.val = v;
    q.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    logic [31:0] obs;
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        0:       obs = rdata;
        1:       obs = {31'd0, redir};
        2:       obs = rpc;
        default: obs = {31'd0, ill};
      endcase
      n_vec++;
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic rd(input string t, input logic [11:0] a,
                    input logic [31:0] v);
    @(negedge clk);
    csrop(RS, 1'b0, a, 5'd0, 32'd0);
    exp(t, 0, v);
    exp({t, "_ill"}, 3, 32'd0);
    chk();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    // reset: redirect suppressed, mtvec at reset value
    csrop(RS, 1'b0, 12'h305, 5'd0, 32'd0);
    ecall = 1'b1;
    exp("rst_redir", 1, 32'd0);
    exp("rst_mtvec", 0, 32'h100);
    chk();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();

    @(negedge clk);
    csrop(RW, 1'b0, 12'h340, 5'd1, 32'hDEAD_BEEF);
    exp("rw_scr_old", 0, 32'd0);
    exp("rw_scr_redir", 1, 32'd0);
    chk();
    rd("scr", 12'h340, 32'hDEAD_BEEF);
    rd("mstatus_rst", 12'h300, 32'h1800);

    @(negedge clk);
    csrop(RS, 1'b1, 12'h300, 5'd8, 32'd0);
    exp("rsi_old", 0, 32'h1800);
    chk();
    @(negedge clk);
    csrop(RC, 1'b0, 12'h300, 5'd0, 32'hFFFF_FFFF);
    exp("rc_x0_old", 0, 32'h1808);
    chk();
    rd("mstatus_mie", 12'h300, 32'h1808);

    @(negedge clk);
    idle();
    valid = 1'b1; ecall = 1'b1; pc = 32'h200;
    exp("ecall_redir", 1, 32'd1);
    exp("ecall_pc", 2, 32'h100);
    chk();
    rd("ecall_mepc", 12'h341, 32'h200);
    rd("ecall_mcause", 12'h342, 32'd11);
    rd("ecall_mstatus", 12'h300, 32'h1880);

    @(negedge clk);
    idle();
    valid = 1'b1; mret = 1'b1;
    exp("mret_redir", 1, 32'd1);
    exp("mret_pc", 2, 32'h200);
    chk();
    rd("mret_mstatus", 12'h300, 32'h1888);

    @(negedge clk);
    csrop(RW, 1'b0, 12'hF14, 5'd2, 32'd5);
    pc = 32'h300;
    exp("ro_ill", 3, 32'd1);
    exp("ro_rdata", 0, 32'd0);
    exp("ro_redir", 1, 32'd1);
    exp("ro_pc", 2, 32'h100);
    chk();
    rd("hartid", 12'hF14, 32'd0);
    rd("ill_mcause", 12'h342, 32'd2);
    rd("ill_mepc", 12'h341, 32'h300);
    rd("ill_mstatus", 12'h300, 32'h1880);

    @(negedge clk);
    csrop(RS, 1'b0, 12'h7C0, 5'd0, 32'd0);
    exp("unimpl_ill", 3, 32'd1);
    chk();
    @(negedge clk);
    csrop(3'b011, 1'b0, 12'h340, 5'd1, 32'd1);
    exp("op_ill", 3, 32'd1);
    chk();
    @(negedge clk);
    csrop(RW, 1'b0, 12'h301, 5'd1, 32'd0);
    exp("misa_ill", 3, 32'd1);
    chk();
    rd("misa", 12'h301, 32'h4000_0100);

    @(negedge clk);
    csrop(RW, 1'b0, 12'h305, 5'd3, 32'h203);
    chk();
    rd("mtvec_align", 12'h305, 32'h200);
    @(negedge clk);
    idle();
    valid = 1'b1; ecall = 1'b1; pc = 32'h44;
    exp("ecall2_pc", 2, 32'h200);
    chk();
    @(negedge clk);
    idle();
    ecall = 1'b1; addr = 12'h7C0; used = 1'b1;
    exp("novalid_redir", 1, 32'd0);
    exp("novalid_ill", 3, 32'd0);
    chk();

    @(negedge clk);
    csrop(RW, 1'b0, 12'hB80, 5'd1, 32'd0);
    chk();
    @(negedge clk);
    csrop(RW, 1'b0, 12'hB00, 5'd1, 32'hFFFF_FFFF);
    chk();
    @(negedge clk);
    idle();
    chk();
    rd("mcycle_wrap", 12'hB00, 32'd0);
    rd("mcycleh_carry", 12'hB80, 32'd1);

    @(negedge clk);
    csrop(RW, 1'b0, 12'hB02, 5'd1, 32'd5);
    chk();
    rd("minstret_wr", 12'hB02, 32'd5);
    rd("minstret_inc", 12'hB02, 32'd6);

    @(negedge clk);
    csrop(RW, 1'b0, 12'h340, 5'd1, 32'h1234_5678);
    chk();
    @(negedge clk);
    rst = 1'b1;
    csrop(RS, 1'b0, 12'h340, 5'd0, 32'd0);
    ecall = 1'b1;
    exp("midrst_scr", 0, 32'd0);
    exp("midrst_redir", 1, 32'd0);
    chk();
    @(negedge clk);
    rst = 1'b0;
    rd("midrst_mtvec", 12'h305, 32'h100);

    @(negedge clk);
    idle();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
